// File: rtl/drum_timing_gen.sv
// Bit/word timing generator for the drum clock domain: free-running or slaved to
// a marker track, with lock tracking and gated timing-pulse decode.
module drum_timing_gen #(
  parameter int unsigned N_BITS     = 29,
  parameter int unsigned N_WORDS    = 108,
  parameter int unsigned GROUP      = 4,
  parameter int unsigned NUM_TAPS   = 4,
  parameter int unsigned LOCK_WORDS = 3,
  parameter int unsigned MISS_LIMIT = 2,
  localparam int unsigned BW = $clog2(N_BITS + 1),
  localparam int unsigned WW = $clog2(N_WORDS)
) (
  input  logic                   CLOCK,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   slave_mode,
  input  logic                   mark_in,
  input  logic                   index_in,
  input  logic                   sign_req,
  input  logic [NUM_TAPS*BW-1:0] tap_bit,
  output logic [BW-1:0]          bit_cnt,
  output logic [WW-1:0]          word_cnt,
  output logic                   T1,
  output logic                   TN,
  output logic                   T0,
  output logic                   TE,
  output logic                   TF,
  output logic                   TS,
  output logic [NUM_TAPS-1:0]    tap_pulse,
  output logic                   locked,
  output logic                   sync_err
);

  localparam int unsigned GW = $clog2(LOCK_WORDS + 1);
  localparam int unsigned MW = $clog2(MISS_LIMIT + 1);

  typedef enum logic [2:0] {S_IDLE, S_FREE, S_HUNT, S_ACQ, S_LOCKED} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [WW-1:0] word_q, word_d;
  logic [GW-1:0] good_q, good_d;
  logic [MW-1:0] miss_q, miss_d;
  logic          ts_q, ts_d;
  logic          sync_err_q, sync_err_d;

  logic          at_tn;
  logic          pulse_en;
  logic          mark_err;
  logic [WW-1:0] word_inc;

  assign at_tn    = (bit_q == BW'(N_BITS));
  assign word_inc = (word_q == WW'(N_WORDS - 1)) ? '0 : word_q + WW'(1);
  assign locked   = (state_q == S_FREE) || (state_q == S_LOCKED);
  assign pulse_en = enable && locked;

  // Timing decode straight off the counters, gated by enable and lock
  assign T1 = pulse_en && (bit_q == BW'(1));
  assign TN = pulse_en && at_tn;
  assign T0 = TN && (word_q == WW'(N_WORDS - 1));
  assign TE = pulse_en && !word_q[0];
  assign TF = TN && ((32'(word_q) % GROUP) == (GROUP - 1));
  assign TS = ts_q && T1;

  always_comb begin
    tap_pulse = '0;
    for (int i = 0; i < int'(NUM_TAPS); i++) begin
      tap_pulse[i] = pulse_en && (tap_bit[i*BW +: BW] == bit_q);
    end
  end

  assign bit_cnt  = bit_q;
  assign word_cnt = word_q;
  assign sync_err = sync_err_q;

  // LOCKED-state marker check: TN must carry a marker (and index only at the last word)
  assign mark_err = at_tn ? (!mark_in || (index_in && (word_q != WW'(N_WORDS - 1))))
                          : mark_in;

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    word_d     = word_q;
    good_d     = good_q;
    miss_d     = miss_q;
    ts_d       = ts_q;
    sync_err_d = 1'b0;

    if (enable) begin
      ts_d = TN ? (!word_inc[0] || sign_req) : 1'b0;
      if (state_q != S_IDLE) begin
        bit_d  = at_tn ? BW'(1) : bit_q + BW'(1);
        word_d = at_tn ? word_inc : word_q;
      end

      unique case (state_q)
        S_IDLE: state_d = slave_mode ? S_HUNT : S_FREE;
        S_FREE: begin
          if (slave_mode) begin
            state_d = S_HUNT;
            good_d  = '0;
          end
        end
        S_HUNT: begin
          if (!slave_mode) begin
            state_d = S_FREE;
          end else if (mark_in) begin
            bit_d   = BW'(1);
            word_d  = index_in ? '0 : word_inc;
            good_d  = GW'(1);
            state_d = (LOCK_WORDS == 1) ? S_LOCKED : S_ACQ;
          end
        end
        S_ACQ: begin
          if (!slave_mode) begin
            state_d = S_FREE;
            good_d  = '0;
          end else if (mark_in && at_tn) begin
            good_d = good_q + GW'(1);
            if (index_in) word_d = '0;
            if (good_q + GW'(1) == GW'(LOCK_WORDS)) begin
              state_d = S_LOCKED;
              good_d  = '0;
              miss_d  = '0;
            end
          end else if (mark_in || at_tn) begin
            state_d = S_HUNT;
            good_d  = '0;
          end
        end
        S_LOCKED: begin
          if (!slave_mode) begin
            state_d = S_FREE;
            miss_d  = '0;
          end else begin
            if (at_tn && index_in) word_d = '0;
            if (mark_err) begin
              if (miss_q + MW'(1) == MW'(MISS_LIMIT)) begin
                state_d    = S_HUNT;
                miss_d     = '0;
                sync_err_d = 1'b1;
              end else begin
                miss_d = miss_q + MW'(1);
              end
            end else if (at_tn) begin
              miss_d = '0;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_q      <= BW'(1);
      word_q     <= '0;
      good_q     <= '0;
      miss_q     <= '0;
      ts_q       <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      word_q     <= word_d;
      good_q     <= good_d;
      miss_q     <= miss_d;
      ts_q       <= ts_d;
      sync_err_q <= sync_err_d;
    end
  end

endmodule
